// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Splits CPU load/store requests into big-endian byte transactions
//            and assembles/extends load data. Optional checks: MEM_ACCESS_ALIGN_CHECK_EN
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 256
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q;
    logic              we_q;
    logic              signed_q;
    logic [2:0]        nbytes_q;
    logic [1:0]        cnt_q;
    logic [31:0]       wshift_q;
    logic [31:0]       asm_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              err_q;

    logic [2:0]        w_req_n;
    logic [31:0]       w_wdata_aligned;
    logic [31:0]       w_asm_d;
    logic [31:0]       w_load_ext;
    logic              w_last;
    logic              w_chk_fail;

    // Store data is left-justified so the first byte to send is always [31:24].
    always_comb begin
        w_req_n         = 3'd4;
        w_wdata_aligned = req_wdata;
        case (req_size)
            2'd0: begin
                w_req_n         = 3'd1;
                w_wdata_aligned = {req_wdata[7:0], 24'h0};
            end
            2'd1: begin
                w_req_n         = 3'd2;
                w_wdata_aligned = {req_wdata[15:0], 16'h0};
            end
            default: begin
                w_req_n         = 3'd4;
                w_wdata_aligned = req_wdata;
            end
        endcase
    end

    always_comb begin
        w_asm_d    = {asm_q[23:0], mem_rdata};
        w_last     = (({1'b0, cnt_q} + 3'd1) == nbytes_q);
        w_load_ext = w_asm_d;
        case (nbytes_q)
            3'd1:    w_load_ext = {{24{signed_q & w_asm_d[7]}}, w_asm_d[7:0]};
            3'd2:    w_load_ext = {{16{signed_q & w_asm_d[15]}}, w_asm_d[15:0]};
            default: w_load_ext = w_asm_d;
        endcase
    end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    localparam int c_SUM_W = ADDR_W + 1;
    logic               w_misaligned;
    logic               w_out_of_range;
    logic [c_SUM_W-1:0] w_end_addr;

    always_comb begin
        w_misaligned   = (req_size == 2'd1) ? req_addr[0]
                       : (req_size[1] ? (req_addr[1:0] != 2'b00) : 1'b0);
        // One extra bit so an access running past the top of the address space is caught.
        w_end_addr     = {1'b0, req_addr} + c_SUM_W'(w_req_n);
        w_out_of_range = (w_end_addr > c_SUM_W'(MEM_BYTES));
        w_chk_fail     = w_misaligned | w_out_of_range;
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (MEM_BYTES != 0);
    assign w_chk_fail   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            nbytes_q     <= 3'd0;
            cnt_q        <= 2'd0;
            wshift_q     <= 32'h0;
            asm_q        <= 32'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        signed_q    <= req_signed;
                        nbytes_q    <= w_req_n;
                        cnt_q       <= 2'd0;
                        asm_q       <= 32'h0;
                        req_ready_q <= 1'b0;
                        if (w_chk_fail) begin
                            state_q      <= S_DONE;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            err_q        <= 1'b1;
                        end else begin
                            state_q     <= S_ACCESS;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= req_addr;
                            mem_wdata_q <= req_we ? w_wdata_aligned[31:24] : 8'h0;
                            wshift_q    <= w_wdata_aligned << 8;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        asm_q <= w_asm_d;
                    end
                    if (w_last) begin
                        state_q      <= S_DONE;
                        mem_en_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_wdata_q  <= 8'h0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= we_q ? 32'h0 : w_load_ext;
                    end else begin
                        cnt_q       <= cnt_q + 2'd1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                        mem_wdata_q <= we_q ? wshift_q[31:24] : 8'h0;
                        wshift_q    <= wshift_q << 8;
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    err_q        <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed, table-driven self-checking bench for mem_access_unit
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:255];

    always #5 CLK = ~CLK;

    mem_access_unit #(.ADDR_W(32), .MEM_BYTES(256)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    // Memory shares the system reset: no writes commit while Reset is high.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge CLK) begin
        if (mem_en && mem_we && !Reset)
            mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_n;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    function automatic logic [7:0] store_byte(input logic [31:0] wd, input int n, input int k);
        logic [31:0] s;
        s = wd >> (8 * (n - 1 - k));
        return s[7:0];
    endfunction

    // Starts and ends on a negedge with the unit idle.
    task automatic run_vec(input vec_t v, input int idx);
        int waited;
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        chk($sformatf("v%0d_ready_wait", idx), {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(negedge CLK);
        req_valid = 1'b0;
        for (int c = 0; c < v.exp_n; c++) begin
            chk($sformatf("v%0d_en_k%0d", idx, c), {31'h0, mem_en}, 32'h1);
            chk($sformatf("v%0d_we_k%0d", idx, c), {31'h0, mem_we}, {31'h0, v.we});
            chk($sformatf("v%0d_addr_k%0d", idx, c), mem_addr, v.addr + 32'(c));
            chk($sformatf("v%0d_rv_k%0d", idx, c), {31'h0, resp_valid}, 32'h0);
            if (v.we)
                chk($sformatf("v%0d_wdata_k%0d", idx, c), {24'h0, mem_wdata},
                    {24'h0, store_byte(v.wdata, v.exp_n, c)});
            @(negedge CLK);
        end
        chk($sformatf("v%0d_resp_valid", idx), {31'h0, resp_valid}, 32'h1);
        chk($sformatf("v%0d_done_en", idx), {31'h0, mem_en}, 32'h0);
        chk($sformatf("v%0d_err", idx), {31'h0, err}, {31'h0, v.exp_err});
        chk($sformatf("v%0d_rdata", idx), resp_rdata, v.exp_rdata);
        @(negedge CLK);
        chk($sformatf("v%0d_pulse_end", idx), {31'h0, resp_valid}, 32'h0);
        chk($sformatf("v%0d_err_end", idx), {31'h0, err}, 32'h0);
        chk($sformatf("v%0d_ready_back", idx), {31'h0, req_ready}, 32'h1);
        chk($sformatf("v%0d_rdata_hold", idx), resp_rdata, v.exp_rdata);
    endtask

    initial begin
        int en_cnt;
        logic [31:0] exp_addr;

        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h10] <= 8'h12; mem[8'h11] <= 8'h34; mem[8'h12] <= 8'h56; mem[8'h13] <= 8'h78;
        mem[8'h14] <= 8'h9A;
        mem[8'h20] <= 8'h85;
        mem[8'h40] <= 8'h01; mem[8'h41] <= 8'h02; mem[8'h42] <= 8'h03; mem[8'h43] <= 8'h04;
        mem[8'hFF] <= 8'hC3; mem[8'h00] <= 8'h5A;

        //           we    size   sgn   addr          wdata         exp_rdata     n  err
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'h12345678, 4, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h20,       32'h0,        32'hFFFFFF85, 1, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h20,       32'h0,        32'h00000085, 1, 1'b0};
        vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h30,       32'hAAAABEEF, 32'h0,        2, 1'b0};
        vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h30,       32'h0,        32'hFFFFBEEF, 2, 1'b0};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h30,       32'h0,        32'h0000BEEF, 2, 1'b0};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h50,       32'hDEADBEEF, 32'h0,        4, 1'b0};
        vecs[7]  = '{1'b0, 2'd2, 1'b1, 32'h50,       32'h0,        32'hDEADBEEF, 4, 1'b0};
        vecs[8]  = '{1'b1, 2'd0, 1'b1, 32'h60,       32'h123456A5, 32'h0,        1, 1'b0};
        vecs[9]  = '{1'b0, 2'd3, 1'b1, 32'h50,       32'h0,        32'hDEADBEEF, 4, 1'b0};
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h41,       32'h0,        32'h0,        0, 1'b1};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'hFE,       32'h0,        32'h0,        0, 1'b1};
`else
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h11,       32'h0,        32'h3456789A, 4, 1'b0};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h0000C35A, 2, 1'b0};
`endif

        Reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        Reset = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
            if (i == 3) begin
                chk("st_half_b0", {24'h0, mem[8'h30]}, 32'hBE);
                chk("st_half_b1", {24'h0, mem[8'h31]}, 32'hEF);
            end
        end
        chk("st_byte", {24'h0, mem[8'h60]}, 32'hA5);
        chk("st_byte_nbr", {24'h0, mem[8'h61]}, 32'h00);

        // Reset during the third ACCESS cycle of a word store.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rstmid_addr_k2", mem_addr, 32'h42);
        chk("rstmid_en_k2", {31'h0, mem_en}, 32'h1);
        Reset = 1'b1;
        @(negedge CLK);
        chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
        chk("rstmid_en", {31'h0, mem_en}, 32'h0);
        chk("rstmid_rv", {31'h0, resp_valid}, 32'h0);
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("rstmid_quiet_rv%0d", c), {31'h0, resp_valid}, 32'h0);
            chk($sformatf("rstmid_quiet_en%0d", c), {31'h0, mem_en}, 32'h0);
        end
        chk("rstmid_b40", {24'h0, mem[8'h40]}, 32'hCA);
        chk("rstmid_b41", {24'h0, mem[8'h41]}, 32'hFE);
        chk("rstmid_b42", {24'h0, mem[8'h42]}, 32'h03);
        chk("rstmid_b43", {24'h0, mem[8'h43]}, 32'h04);

        // Back-to-back word loads with req_valid held high throughout.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        en_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (c == 1) req_addr = 32'h50;
            if (mem_en) en_cnt++;
            if (c <= 4 || (c >= 7 && c <= 10)) begin
                exp_addr = (c <= 4) ? 32'h10 + 32'(c - 1) : 32'h50 + 32'(c - 7);
                chk($sformatf("b2b_en_c%0d", c), {31'h0, mem_en}, 32'h1);
                chk($sformatf("b2b_addr_c%0d", c), mem_addr, exp_addr);
                chk($sformatf("b2b_ready_c%0d", c), {31'h0, req_ready}, 32'h0);
            end else if (c == 5 || c == 11) begin
                chk($sformatf("b2b_rv_c%0d", c), {31'h0, resp_valid}, 32'h1);
                chk($sformatf("b2b_rdata_c%0d", c), resp_rdata,
                    (c == 5) ? 32'h12345678 : 32'hDEADBEEF);
                chk($sformatf("b2b_ready_c%0d", c), {31'h0, req_ready}, 32'h0);
            end else if (c == 6) begin
                chk("b2b_idle_ready", {31'h0, req_ready}, 32'h1);
                chk("b2b_idle_en", {31'h0, mem_en}, 32'h0);
                chk("b2b_idle_rv", {31'h0, resp_valid}, 32'h0);
            end
            if (c == 7) req_valid = 1'b0;
        end
        chk("b2b_en_total", 32'(en_cnt), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
